muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/alu_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_sequencer.sv | 117 +++++++++++
 tb/tb_muldiv_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// flag bit positions and the flag-building helper.
package alu_pkg;

    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SMUL = 3'b101;
    localparam logic [2:0] OP_UMUL = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Wide multiplies report on the full 64-bit product, everything else on Result.
    function automatic logic [3:0] mk_flags(input logic [2:0] op, input logic [31:0] res,
                                            input logic [31:0] hi_w, input logic v);
        logic [3:0] f;
        logic       wide;
        wide      = (op == OP_SMUL) || (op == OP_UMUL);
        f         = '0;
        f[FLAG_N] = wide ? hi_w[31] : res[31];
        f[FLAG_Z] = (res == '0) && (!wide || (hi_w == '0));
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply on {hi,lo}, or restoring divide
// step with hi as partial remainder and lo as dividend/quotient.
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] opnd,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt
);

    logic [32:0] sum;
    logic [32:0] shl;
    logic [32:0] diff;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
        shl  = {hi, lo[31]};
        // Partial remainder stays below the divisor, so bit 32 is a clean borrow.
        diff = shl - {1'b0, opnd};
        if (is_div) begin
            if (!diff[32]) begin
                hi_nxt = diff[31:0];
                lo_nxt = {lo[30:0], 1'b1};
            end else begin
                hi_nxt = shl[31:0];
                lo_nxt = {lo[30:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[32:1];
            lo_nxt = {sum[0], lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit: IDLE -> CALC (ITER steps) -> FIX -> DONE,
// with a valid/ready result handshake and a synchronous flush.
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] Result,
    output logic [31:0] Long,
    output logic [3:0]  ALUFlags,
    output logic        busy
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic          neg_q;
    logic [31:0]   hi, lo, opnd;
    logic [31:0]   hi_step, lo_step;
    logic [31:0]   mag_a, mag_b;
    logic          accept, load, dbz;
    logic [63:0]   prod;
    logic [31:0]   done_res, done_long;
    logic [3:0]    done_flags;

    assign start_ready = (state == S_IDLE) && !flush;
    assign accept      = start_valid && start_ready;
    assign load        = accept && op[2];
    assign dbz         = (op == OP_DIV) && (b == '0);
    assign busy        = (state != S_IDLE);
    assign res_valid   = (state == S_DONE);

    assign mag_a = ((op == OP_SMUL) && a[31]) ? -a : a;
    assign mag_b = ((op == OP_SMUL) && b[31]) ? -b : b;

    muldiv_step u_step (
        .is_div (op_q == OP_DIV),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd),
        .hi_nxt (hi_step),
        .lo_nxt (lo_step)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load) state_nxt = dbz ? S_DONE : S_CALC;
            S_CALC:  if (cnt == CW'(ITER - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Divide leaves {remainder, quotient} in {hi,lo}, so one mux serves every op.
    always_comb begin
        prod = neg_q ? -{hi, lo} : {hi, lo};
        if (state == S_IDLE) begin
            done_res   = '1;
            done_long  = a;
            done_flags = mk_flags(OP_DIV, '1, a, 1'b1);
        end else begin
            done_res   = prod[31:0];
            done_long  = (op_q == OP_MUL) ? '0 : prod[63:32];
            done_flags = mk_flags(op_q, done_res, done_long, 1'b0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            Result   <= '0;
            Long     <= '0;
            ALUFlags <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                op_q  <= op;
                neg_q <= (op == OP_SMUL) && (a[31] ^ b[31]);
                cnt   <= '0;
                hi    <= '0;
                lo    <= (op == OP_DIV) ? a : mag_b;
                opnd  <= (op == OP_DIV) ? b : mag_a;
            end else if (state == S_CALC) begin
                hi  <= hi_step;
                lo  <= lo_step;
                cnt <= cnt + 1'b1;
            end
            if ((state_nxt == S_DONE) && (state != S_DONE)) begin
                Result   <= done_res;
                Long     <= done_long;
                ALUFlags <= done_flags;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] Result, Long;
    logic [3:0]  ALUFlags;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [3:0]  flg;
        int          cyc;
    } item_t;

    item_t sbq[$];
    int    n_cmp = 0, n_bad = 0;
    int    cyc = 0;
    bit    hold = 1'b0;

    muldiv_sequencer #(.ITER(ITER)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a(a), .b(b), .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
        .Result(Result), .Long(Long), .ALUFlags(ALUFlags), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        res_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [31:0] r, input logic [31:0] l, input logic [3:0] f);
        item_t it;
        it.res = r; it.hi = l; it.flg = f; it.cyc = 0;
        return it;
    endfunction

    // Reference: plain arithmetic on the operands, flags {N,Z,C,V}.
    function automatic item_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] r, l;
        logic        v, n, z;
        longint      sx, sy;
        v = 1'b0;
        p = 64'(x) * 64'(y);
        r = p[31:0];
        l = p[63:32];
        if (o == 3'b100) begin
            l = '0;
        end else if (o == 3'b101) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = 64'(sx * sy);
            r  = p[31:0];
            l  = p[63:32];
        end else if (o == 3'b111) begin
            if (y == 0) begin
                r = 32'hFFFF_FFFF; l = x; v = 1'b1;
            end else begin
                r = x / y; l = x % y;
            end
        end
        if (o == 3'b101 || o == 3'b110) begin
            n = l[31]; z = ({l, r} == 64'd0);
        end else begin
            n = r[31]; z = (r == 0);
        end
        return mk(r, l, {n, z, 1'b0, v});
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input item_t it);
        int  guard = 0;
        bit  ok = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b1; op = o; a = x; b = y;
        while (!ok && guard < 500) begin
            @(negedge clk);
            if (start_ready) ok = 1'b1;
            guard++;
        end
        if (!ok) begin
            chk("accept_timeout", 64'(start_ready), 64'd1);
        end else if (push) begin
            // Result appears ITER+1 edges after the accepting edge, or on it for /0.
            it.cyc = cyc + (((o == 3'b111) && (y == 0)) ? 1 : ITER + 2);
            sbq.push_back(it);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((sbq.size() != 0 || busy) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    task automatic no_result_window(input string nm);
        int seen = 0;
        repeat (ITER + 5) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    // Monitor: pops on each new result, re-checks the values at handoff.
    item_t cur;
    bit    prev_v = 1'b0;
    bit    have = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_v = 1'b0;
            have   = 1'b0;
        end else begin
            if (res_valid && !prev_v) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    have = 1'b0;
                    $display("FAIL unexpected_result: got res_valid=1 want no pending op (t=%0t)", $time);
                end else begin
                    cur  = sbq.pop_front();
                    have = 1'b1;
                    chk("latency", 64'(cyc), 64'(cur.cyc));
                    chk("result", 64'(Result), 64'(cur.res));
                    chk("long", 64'(Long), 64'(cur.hi));
                    chk("flags", 64'(ALUFlags), 64'(cur.flg));
                end
            end
            if (res_valid && res_ready && have) begin
                chk("handoff_value", {Long, Result}, {cur.hi, cur.res});
                chk("handoff_flags", 64'(ALUFlags), 64'(cur.flg));
                chk("no_accept_at_handoff", 64'(start_ready), 64'd0);
            end
            prev_v = res_valid;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        @(negedge clk);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_long", 64'(Long), 64'd0);
        chk("rst_flags", 64'(ALUFlags), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(start_ready), 64'd1);

        issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(32'h0000_0001, 32'hFFFF_FFFE, 4'b1000));
        issue(3'b101, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, mk(32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000));

        // Consumer stalls: result must hold and no new op may be taken.
        drain();
        hold = 1'b1;
        issue(3'b100, 32'd0, 32'd12345, 1'b1, mk(32'd0, 32'd0, 4'b0100));
        begin
            int g = 0;
            while (!res_valid && g < 100) begin @(negedge clk); g++; end
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_value", {Long, Result, 28'd0, ALUFlags}, {64'd0, 28'd0, 4'b0100});
            chk("hold_ready", 64'(start_ready), 64'd0);
            @(negedge clk);
        end
        hold = 1'b0;

        issue(3'b111, 32'd100, 32'd7, 1'b1, mk(32'd14, 32'd2, 4'b0000));
        issue(3'b111, 32'd100, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'd100, 4'b1001));
        drain();

        // Reset mid-CALC wipes the held result and abandons the op.
        issue(3'b111, 32'd1000, 32'd3, 1'b0, mk(0, 0, 0));
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {Long, Result}, 64'd0);
        chk("midrst_flags", 64'(ALUFlags), 64'd0);
        chk("midrst_valid_busy", {62'd0, res_valid, busy}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(start_ready), 64'd1);
        no_result_window("midrst_no_result");

        // Flush in CALC cycle 10 together with a new request: flush wins.
        issue(3'b110, $urandom, $urandom, 1'b0, mk(0, 0, 0));
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; start_valid = 1'b1; op = 3'b110;
        @(negedge clk);
        chk("flush_blocks_ready", 64'(start_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        chk("flush_to_idle", {61'd0, busy, res_valid, start_ready}, 64'd1);
        no_result_window("flush_no_result");

        // op[2]==0 is accepted but dropped.
        issue(3'b010, 32'd5, 32'd6, 1'b0, mk(0, 0, 0));
        @(negedge clk);
        chk("dropped_busy", 64'(busy), 64'd0);
        no_result_window("dropped_no_result");

        for (int i = 0; i < 40; i++) begin
            ro = 3'b100 + 3'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = $urandom_range(0, 255);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'h8000_0000;
                2: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb, 1'b1, model(ro, ra, rb));
        end
        drain();
        chk("queue_empty", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
